// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplies use shift-add and divides use restoring division, one bit per cycle on
// operand magnitudes. A single FIX cycle then applies the sign correction and writes HI/LO.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  // Multiply: {partial product, remaining multiplier bits}. Divide: low half is the
  // dividend shifting out while quotient bits shift in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               in_signed, in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Next-state, datapath step and sign correction.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = 1'b0;

    // op[0]=0 selects the signed variants.
    in_signed = ~op[0];
    in_neg_a  = in_signed & a[WIDTH-1];
    in_neg_b  = in_signed & b[WIDTH-1];
    in_mag_a  = in_neg_a ? -a : a;
    in_mag_b  = in_neg_b ? -b : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -rem_q : rem_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          is_div_d = op[1];
          sign_a_d = in_neg_a;
          sign_b_d = in_neg_b;
          mag_a_d  = in_mag_a;
          mag_b_d  = in_mag_b;
          cnt_d    = CntW'(WIDTH);
          rem_d    = '0;
          acc_d    = op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
          if (op[1] && (b == '0)) begin
            state_d = StDone;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (is_div_q) begin
          // Restoring step: keep the subtraction only when it did not borrow.
          rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): reset, signed/unsigned multiply and divide,
// divide-by-zero, ignored start/MTHI while busy, back-to-back ops and reset mid-operation.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives start at the current negedge and follows the op until done (bounded).
  // inject!=0 raises start (DIVU 9/3) and hi_we for one cycle at that cycle count.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inject, output int cycles, output int busy_cycles,
                        output bit hold_ok);
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    hold_ok = 1'b1;
    cycles = 0;
    busy_cycles = 0;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (inject != 0 && cycles == inject) begin
        start = 1'b1;
        op = 2'b11;
        a = 32'd9;
        b = 32'd3;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      if (busy) busy_cycles++;
      if (done) break;
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_dbz got %0b want 0", div_by_zero);
    end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int cyc, bcyc;
    bit hold;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, bcyc, hold);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", cyc); end
    checks++; if (bcyc !== 33) begin errors++; $display("FAIL multu_busy got %0d want 33", bcyc); end
    checks++; if (!hold) begin errors++; $display("FAIL multu_hold got changed want stable"); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++; $display("FAIL multu_dbz got %0b want 0", div_by_zero);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %0b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_mult_signed();
    int cyc, bcyc;
    bit hold;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, cyc, bcyc, hold);
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg_lo got %h want fffffff1", lo); end
    run_op(2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 0, cyc, bcyc, hold);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_pos_hi got %h want 00000000", hi); end
    checks++; if (lo !== 32'h14) begin errors++; $display("FAIL mult_pos_lo got %h want 00000014", lo); end
  endtask

  task automatic test_div();
    int cyc, bcyc;
    bit hold;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 0, cyc, bcyc, hold);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
    run_op(2'b10, 32'h7, 32'hFFFF_FFFE, 0, cyc, bcyc, hold);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL div_negb_hi got %h want 00000001", hi); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bcyc, hold);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_wrap_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_wrap_hi got %h want 00000000", hi); end
    run_op(2'b11, 32'd100, 32'd7, 0, cyc, bcyc, hold);
    checks++; if (lo !== 32'h0E) begin errors++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    checks++; if (hi !== 32'h2) begin errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
  endtask

  task automatic test_div_zero();
    int cyc, bcyc;
    bit hold;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h want 12345678", hi); end
    checks++; if (lo !== 32'h1234_5678) begin errors++; $display("FAIL mtlo got %h want 12345678", lo); end
    // A concurrent MTLO must lose to start.
    lo_we = 1'b1;
    wdata = 32'hAAAA_5555;
    run_op(2'b11, 32'd100, 32'd0, 0, cyc, bcyc, hold);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", cyc); end
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_flag got %0b want 1", div_by_zero);
    end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL dbz_hi got %h want 12345678", hi); end
    checks++; if (lo !== 32'h1234_5678) begin errors++; $display("FAIL dbz_lo got %h want 12345678", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dbz_pulse got %0b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    bit hold;
    run_op(2'b01, 32'd3, 32'd4, 10, cyc, bcyc, hold);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL ignore_latency got %0d want 34", cyc); end
    checks++; if (!hold) begin errors++; $display("FAIL ignore_hold got changed want stable"); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0C) begin errors++; $display("FAIL ignore_lo got %h want 0000000c", lo); end
    // Launch straight from the DONE cycle.
    run_op(2'b01, 32'd5, 32'd6, 0, cyc, bcyc, hold);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", cyc); end
    checks++; if (lo !== 32'h1E) begin errors++; $display("FAIL b2b_lo got %h want 0000001e", lo); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    start = 1'b1;
    op = 2'b10;
    a = 32'd1000;
    b = 32'd7;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h want 0", lo); end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rstmid_done got 1 want never"); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    @(negedge clk);
    test_reset();
    test_multu();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
